// File: rtl/bus_master_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// bus_arb_pkg
// Shared types and limits for the basil register-bus master arbiter.
//   arb_state_t       : IDLE (may accept a request) / RD_WAIT (read outstanding)
//   MAX_MASTERS       : upper bound on the number of requesters
//   MAX_READ_LATENCY  : upper bound on slave read latency in BUS_CLK cycles
// -----------------------------------------------------------------------------
package bus_arb_pkg;

    localparam int unsigned MAX_MASTERS      = 8;
    localparam int unsigned MAX_READ_LATENCY = 3;

    typedef enum logic {
        IDLE    = 1'b0,
        RD_WAIT = 1'b1
    } arb_state_t;

endpackage

// File: rtl/bus_master_arbiter_rr_core.sv
// -----------------------------------------------------------------------------
// rr_arbiter_core
// Combinational winner selection for bus_master_arbiter.
// Default: round-robin, searching OWNER+1, OWNER+2, ... modulo N_MASTERS.
// Build macro BUS_ARB_FIXED_PRIO_EN: fixed priority, lowest index wins.
// While lock is set only the current owner is eligible, in both modes.
// Ports:
//   req         in   per-master request vector
//   owner       in   index of last/current grantee
//   lock        in   ownership lock held by owner
//   grant       out  one-hot grant (all zero when nobody eligible)
//   grant_idx   out  index of the granted master
//   grant_valid out  a grant was made
// -----------------------------------------------------------------------------
module rr_arbiter_core #(
    parameter int unsigned N_MASTERS = 2
) (
    input  logic [N_MASTERS-1:0]         req,
    input  logic [$clog2(N_MASTERS)-1:0] owner,
    input  logic                         lock,
    output logic [N_MASTERS-1:0]         grant,
    output logic [$clog2(N_MASTERS)-1:0] grant_idx,
    output logic                         grant_valid
);

    localparam int unsigned IW = $clog2(N_MASTERS);

    int unsigned      cand;
    logic [IW-1:0]    cand_idx;

    always_comb begin
        grant       = '0;
        grant_idx   = '0;
        grant_valid = 1'b0;
        cand        = 0;
        cand_idx    = '0;

        if (lock) begin
            if (req[owner]) begin
                grant[owner] = 1'b1;
                grant_idx    = owner;
                grant_valid  = 1'b1;
            end
        end else begin
`ifdef BUS_ARB_FIXED_PRIO_EN
            // Walk from the highest index down so the lowest requester wins.
            for (int unsigned k = 0; k < N_MASTERS; k++) begin
                cand     = N_MASTERS - 1 - k;
                cand_idx = IW'(cand);
                if (req[cand_idx]) begin
                    grant       = '0;
                    grant[cand_idx] = 1'b1;
                    grant_idx   = cand_idx;
                    grant_valid = 1'b1;
                end
            end
`else
            // k = N_MASTERS wraps to owner itself, so a lone owner can re-win.
            for (int unsigned k = 1; k <= N_MASTERS; k++) begin
                cand = 32'(owner) + k;
                if (cand >= N_MASTERS) cand = cand - N_MASTERS;
                cand_idx = IW'(cand);
                if (!grant_valid && req[cand_idx]) begin
                    grant[cand_idx] = 1'b1;
                    grant_idx       = cand_idx;
                    grant_valid     = 1'b1;
                end
            end
`endif
        end
    end

endmodule

// File: rtl/bus_master_arbiter.sv
// -----------------------------------------------------------------------------
// bus_master_arbiter
// Shares the basil register bus between N_MASTERS single-byte requesters.
// Requests are accepted with a combinational ACK pulse; the bus strobes,
// address and write data are registered and appear the cycle after ACK.
// Reads wait READ_LATENCY cycles after BUS_RD, then return data with a
// registered one-hot RD_VALID to the issuing master. REQ_LOCK keeps the bus
// with the current owner for bursts.
// Build macro BUS_ARB_FIXED_PRIO_EN selects fixed-priority arbitration
// (lowest index wins) instead of round-robin.
// Ports:
//   BUS_CLK, BUS_RST     clock, synchronous active-high reset
//   REQ/REQ_WR/REQ_LOCK  per-master valid, write flag, lock request
//   REQ_ADD/REQ_DATA     packed per-master address / write byte
//   ACK                  one-hot accept pulse (combinational)
//   RD_VALID/RD_DATA     one-hot read return pulse and byte (registered)
//   OWNER                index of last/current grantee
//   BUS_WR/BUS_RD/BUS_ADD registered bus strobes and address
//   BUS_DATA             driven with write data while BUS_WR=1, else Z
// -----------------------------------------------------------------------------
module bus_master_arbiter
    import bus_arb_pkg::*;
#(
    parameter int unsigned N_MASTERS    = 2,
    parameter int unsigned ABUSWIDTH    = 32,
    parameter int unsigned READ_LATENCY = 1
) (
    input  logic                           BUS_CLK,
    input  logic                           BUS_RST,
    input  logic [N_MASTERS-1:0]           REQ,
    input  logic [N_MASTERS-1:0]           REQ_WR,
    input  logic [N_MASTERS-1:0]           REQ_LOCK,
    input  logic [N_MASTERS*ABUSWIDTH-1:0] REQ_ADD,
    input  logic [N_MASTERS*8-1:0]         REQ_DATA,
    output logic [N_MASTERS-1:0]           ACK,
    output logic [N_MASTERS-1:0]           RD_VALID,
    output logic [7:0]                     RD_DATA,
    output logic [$clog2(N_MASTERS)-1:0]   OWNER,
    output logic                           BUS_WR,
    output logic                           BUS_RD,
    output logic [ABUSWIDTH-1:0]           BUS_ADD,
    inout  wire  [7:0]                     BUS_DATA
);

    localparam int unsigned IW = $clog2(N_MASTERS);
    localparam int unsigned CW = $clog2(MAX_READ_LATENCY + 1);
    localparam logic [IW-1:0] OWNER_RST = IW'(N_MASTERS - 1);
    localparam logic [CW-1:0] RL_CNT    = CW'(READ_LATENCY);

    if (N_MASTERS < 2 || N_MASTERS > MAX_MASTERS) begin : g_bad_n_masters
        $error("bus_master_arbiter: N_MASTERS out of range");
    end
    if (READ_LATENCY < 1 || READ_LATENCY > MAX_READ_LATENCY) begin : g_bad_latency
        $error("bus_master_arbiter: READ_LATENCY out of range");
    end

    arb_state_t             state, state_nxt;
    logic                   lock_q, lock_nxt;
    logic [CW-1:0]          lat_cnt;
    logic [7:0]             wdata;

    logic [N_MASTERS-1:0]   grant;
    logic [IW-1:0]          grant_idx;
    logic                   grant_valid;
    logic                   accept;
    logic                   capture;

    rr_arbiter_core #(
        .N_MASTERS (N_MASTERS)
    ) u_core (
        .req         (REQ),
        .owner       (OWNER),
        .lock        (lock_q),
        .grant       (grant),
        .grant_idx   (grant_idx),
        .grant_valid (grant_valid)
    );

    always_comb begin
        state_nxt = state;
        lock_nxt  = lock_q;
        accept    = 1'b0;
        capture   = 1'b0;
        ACK       = '0;

        case (state)
            IDLE: begin
                if (grant_valid) begin
                    accept   = 1'b1;
                    ACK      = grant;
                    // While locked only the owner can be accepted, so this
                    // single assignment both sets and releases the lock.
                    lock_nxt = REQ_LOCK[grant_idx];
                    if (!REQ_WR[grant_idx]) state_nxt = RD_WAIT;
                end else if (lock_q && !REQ[OWNER] && !REQ_LOCK[OWNER]) begin
                    lock_nxt = 1'b0;
                end
            end
            RD_WAIT: begin
                // lat_cnt is 0 in the BUS_RD cycle, so data is captured at
                // the end of the cycle READ_LATENCY after the strobe.
                if (lat_cnt == RL_CNT) begin
                    capture   = 1'b1;
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge BUS_CLK) begin
        if (BUS_RST) begin
            state    <= IDLE;
            lock_q   <= 1'b0;
            lat_cnt  <= '0;
            OWNER    <= OWNER_RST;
            BUS_WR   <= 1'b0;
            BUS_RD   <= 1'b0;
            BUS_ADD  <= '0;
            wdata    <= '0;
            RD_VALID <= '0;
            RD_DATA  <= '0;
        end else begin
            state    <= state_nxt;
            lock_q   <= lock_nxt;
            BUS_WR   <= accept &  REQ_WR[grant_idx];
            BUS_RD   <= accept & ~REQ_WR[grant_idx];
            RD_VALID <= '0;

            if (accept) begin
                OWNER   <= grant_idx;
                BUS_ADD <= REQ_ADD[grant_idx*ABUSWIDTH +: ABUSWIDTH];
                wdata   <= REQ_DATA[grant_idx*8 +: 8];
                lat_cnt <= '0;
            end else if (state == RD_WAIT) begin
                lat_cnt <= lat_cnt + 1'b1;
            end

            if (capture) begin
                RD_VALID[OWNER] <= 1'b1;
                RD_DATA         <= BUS_DATA;
            end
        end
    end

    assign BUS_DATA = BUS_WR ? wdata : 'z;

endmodule

// File: tb/tb_bus_master_arbiter.sv
// -----------------------------------------------------------------------------
// tb_bus_master_arbiter
// Directed bench for bus_master_arbiter (N_MASTERS=2, ABUSWIDTH=32,
// READ_LATENCY=1). Write/lock/fairness traffic comes from a vector table;
// read return and reset-during-read are hand-written sequences. A small slave
// model drives BUS_DATA one cycle after BUS_RD.
// Build macro BUS_ARB_FIXED_PRIO_EN switches the fairness expectations.
// -----------------------------------------------------------------------------
module tb_bus_master_arbiter;

`ifdef BUS_ARB_FIXED_PRIO_EN
    localparam bit FP = 1'b1;
`else
    localparam bit FP = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  req, req_wr, req_lock;
    logic [31:0] add0, add1;
    logic [7:0]  d0, d1;
    logic [1:0]  ack, rd_valid;
    logic [7:0]  rd_data;
    logic        owner;
    logic        bus_wr, bus_rd;
    logic [31:0] bus_add;
    wire  [7:0]  bus_data;

    logic        rd_d = 1'b0;
    logic [7:0]  slave_val = 8'h00;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    // Slave answers one cycle after the read strobe.
    always @(posedge clk) rd_d <= bus_rd;
    assign bus_data = rd_d ? slave_val : 8'bz;

    bus_master_arbiter #(
        .N_MASTERS    (2),
        .ABUSWIDTH    (32),
        .READ_LATENCY (1)
    ) dut (
        .BUS_CLK  (clk),
        .BUS_RST  (rst),
        .REQ      (req),
        .REQ_WR   (req_wr),
        .REQ_LOCK (req_lock),
        .REQ_ADD  ({add1, add0}),
        .REQ_DATA ({d1, d0}),
        .ACK      (ack),
        .RD_VALID (rd_valid),
        .RD_DATA  (rd_data),
        .OWNER    (owner),
        .BUS_WR   (bus_wr),
        .BUS_RD   (bus_rd),
        .BUS_ADD  (bus_add),
        .BUS_DATA (bus_data)
    );

    typedef struct {
        logic [1:0]  req, wr, lock;
        logic [31:0] add0, add1;
        logic [7:0]  d0, d1;
        logic [1:0]  ack;
        logic        bwr;
        logic [31:0] badd;
        logic [7:0]  bdata;
        logic        owner;
    } vec_t;

    vec_t vecs[$];

    task automatic av(input logic [1:0] r, input logic [1:0] w, input logic [1:0] l,
                      input logic [31:0] a0, input logic [31:0] a1,
                      input logic [7:0] x0, input logic [7:0] x1,
                      input logic [1:0] eack, input logic ebwr,
                      input logic [31:0] ebadd, input logic [7:0] ebdata,
                      input logic eown);
        vec_t v;
        v.req = r; v.wr = w; v.lock = l;
        v.add0 = a0; v.add1 = a1; v.d0 = x0; v.d1 = x1;
        v.ack = eack; v.bwr = ebwr; v.badd = ebadd; v.bdata = ebdata; v.owner = eown;
        vecs.push_back(v);
    endtask

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    task automatic drive(input logic [1:0] r, input logic [1:0] w, input logic [1:0] l,
                         input logic [31:0] a0, input logic [31:0] a1,
                         input logic [7:0] x0, input logic [7:0] x1);
        req = r; req_wr = w; req_lock = l;
        add0 = a0; add1 = a1; d0 = x0; d1 = x1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        rst = 1'b1;
        drive(2'b00, 2'b00, 2'b00, 0, 0, 0, 0);

        // Fill the table: inputs, expected ACK this cycle, bus state from the
        // previous cycle's accept, and OWNER.
        av(2'b00, 2'b11, 2'b00, 32'h0,    32'h0,   8'h00, 8'h00, 2'b00, 1'b0, 32'h0,    8'h00, 1'b1);
        av(2'b01, 2'b11, 2'b00, 32'h1000, 32'h0,   8'hA5, 8'h00, 2'b01, 1'b0, 32'h0,    8'h00, 1'b1);
        av(2'b00, 2'b11, 2'b00, 32'h1000, 32'h0,   8'hA5, 8'h00, 2'b00, 1'b1, 32'h1000, 8'hA5, 1'b0);
        av(2'b00, 2'b11, 2'b00, 32'h1000, 32'h0,   8'hA5, 8'h00, 2'b00, 1'b0, 32'h1000, 8'h00, 1'b0);
        // Both masters stream writes.
        av(2'b11, 2'b11, 2'b00, 32'h10,   32'h11,  8'h01, 8'h02, FP ? 2'b01 : 2'b10, 1'b0, 32'h1000, 8'h00, 1'b0);
        av(2'b11, 2'b11, 2'b00, 32'h10,   32'h11,  8'h01, 8'h02, 2'b01, 1'b1,
           FP ? 32'h10 : 32'h11, FP ? 8'h01 : 8'h02, FP ? 1'b0 : 1'b1);
        av(2'b11, 2'b11, 2'b00, 32'h10,   32'h11,  8'h01, 8'h02, FP ? 2'b01 : 2'b10, 1'b1, 32'h10, 8'h01, 1'b0);
        av(2'b11, 2'b11, 2'b00, 32'h10,   32'h11,  8'h01, 8'h02, 2'b01, 1'b1,
           FP ? 32'h10 : 32'h11, FP ? 8'h01 : 8'h02, FP ? 1'b0 : 1'b1);
        av(2'b00, 2'b11, 2'b00, 32'h10,   32'h11,  8'h01, 8'h02, 2'b00, 1'b1, 32'h10,   8'h01, 1'b0);
        av(2'b00, 2'b11, 2'b00, 32'h10,   32'h11,  8'h01, 8'h02, 2'b00, 1'b0, 32'h10,   8'h00, 1'b0);
        // Locked 4-byte burst from master 1 while master 0 waits.
        av(2'b10, 2'b11, 2'b10, 32'h200,  32'h100, 8'h55, 8'hB0, 2'b10, 1'b0, 32'h10,   8'h00, 1'b0);
        av(2'b11, 2'b11, 2'b10, 32'h200,  32'h101, 8'h55, 8'hB1, 2'b10, 1'b1, 32'h100,  8'hB0, 1'b1);
        av(2'b11, 2'b11, 2'b10, 32'h200,  32'h102, 8'h55, 8'hB2, 2'b10, 1'b1, 32'h101,  8'hB1, 1'b1);
        av(2'b11, 2'b11, 2'b00, 32'h200,  32'h103, 8'h55, 8'hB3, 2'b10, 1'b1, 32'h102,  8'hB2, 1'b1);
        av(2'b01, 2'b11, 2'b00, 32'h200,  32'h103, 8'h55, 8'hB3, 2'b01, 1'b1, 32'h103,  8'hB3, 1'b1);
        av(2'b00, 2'b11, 2'b00, 32'h200,  32'h103, 8'h55, 8'hB3, 2'b00, 1'b1, 32'h200,  8'h55, 1'b0);
        av(2'b00, 2'b11, 2'b00, 32'h200,  32'h103, 8'h55, 8'hB3, 2'b00, 1'b0, 32'h200,  8'h00, 1'b0);
        // Lock stall: owner drops REQ but keeps LOCK for three cycles.
        av(2'b10, 2'b11, 2'b10, 32'h400,  32'h300, 8'h66, 8'hC0, 2'b10, 1'b0, 32'h200,  8'h00, 1'b0);
        av(2'b01, 2'b11, 2'b10, 32'h400,  32'h300, 8'h66, 8'hC0, 2'b00, 1'b1, 32'h300,  8'hC0, 1'b1);
        av(2'b01, 2'b11, 2'b10, 32'h400,  32'h300, 8'h66, 8'hC0, 2'b00, 1'b0, 32'h300,  8'h00, 1'b1);
        av(2'b01, 2'b11, 2'b10, 32'h400,  32'h300, 8'h66, 8'hC0, 2'b00, 1'b0, 32'h300,  8'h00, 1'b1);
        av(2'b11, 2'b11, 2'b00, 32'h400,  32'h301, 8'h66, 8'hC1, 2'b10, 1'b0, 32'h300,  8'h00, 1'b1);
        av(2'b01, 2'b11, 2'b00, 32'h400,  32'h301, 8'h66, 8'hC1, 2'b01, 1'b1, 32'h301,  8'hC1, 1'b1);
        av(2'b00, 2'b11, 2'b00, 32'h400,  32'h301, 8'h66, 8'hC1, 2'b00, 1'b1, 32'h400,  8'h66, 1'b0);
        // Lock released by owner dropping both REQ and LOCK.
        av(2'b10, 2'b11, 2'b10, 32'h600,  32'h500, 8'h77, 8'hD0, 2'b10, 1'b0, 32'h400,  8'h00, 1'b0);
        av(2'b00, 2'b11, 2'b00, 32'h600,  32'h500, 8'h77, 8'hD0, 2'b00, 1'b1, 32'h500,  8'hD0, 1'b1);
        av(2'b01, 2'b11, 2'b00, 32'h600,  32'h500, 8'h77, 8'hD0, 2'b01, 1'b0, 32'h500,  8'h00, 1'b1);
        av(2'b00, 2'b11, 2'b00, 32'h600,  32'h500, 8'h77, 8'hD0, 2'b00, 1'b1, 32'h600,  8'h77, 1'b0);

        repeat (2) @(negedge clk);
        rst = 1'b0;

        foreach (vecs[i]) begin
            @(negedge clk);
            drive(vecs[i].req, vecs[i].wr, vecs[i].lock, vecs[i].add0, vecs[i].add1,
                  vecs[i].d0, vecs[i].d1);
            #1;
            chk($sformatf("v%0d.ack", i),      {30'd0, ack},      {30'd0, vecs[i].ack});
            chk($sformatf("v%0d.bus_wr", i),   {31'd0, bus_wr},   {31'd0, vecs[i].bwr});
            chk($sformatf("v%0d.bus_rd", i),   {31'd0, bus_rd},   32'd0);
            chk($sformatf("v%0d.bus_add", i),  bus_add,           vecs[i].badd);
            chk($sformatf("v%0d.owner", i),    {31'd0, owner},    {31'd0, vecs[i].owner});
            chk($sformatf("v%0d.rd_valid", i), {30'd0, rd_valid}, 32'd0);
            if (vecs[i].bwr)
                chk($sformatf("v%0d.bus_data", i), {24'd0, bus_data}, {24'd0, vecs[i].bdata});
        end

        // Read by master 1 (owner is 0); master 0 queues a write meanwhile.
        slave_val = 8'h3C;
        @(negedge clk);
        drive(2'b10, 2'b00, 2'b00, 32'h0, 32'h20, 8'h00, 8'h00); #1;
        chk("rd.t0.ack", {30'd0, ack}, 32'h2);
        @(negedge clk);
        drive(2'b01, 2'b01, 2'b00, 32'h700, 32'h20, 8'h88, 8'h00); #1;
        chk("rd.t1.ack",     {30'd0, ack},     32'h0);
        chk("rd.t1.bus_rd",  {31'd0, bus_rd},  32'h1);
        chk("rd.t1.bus_wr",  {31'd0, bus_wr},  32'h0);
        chk("rd.t1.bus_add", bus_add,          32'h20);
        chk("rd.t1.owner",   {31'd0, owner},   32'h1);
        chk("rd.t1.rd_valid",{30'd0, rd_valid},32'h0);
        @(negedge clk); #1;
        chk("rd.t2.ack",     {30'd0, ack},     32'h0);
        chk("rd.t2.bus_rd",  {31'd0, bus_rd},  32'h0);
        chk("rd.t2.rd_valid",{30'd0, rd_valid},32'h0);
        @(negedge clk); #1;
        chk("rd.t3.rd_valid",{30'd0, rd_valid},32'h2);
        chk("rd.t3.rd_data", {24'd0, rd_data}, 32'h3C);
        chk("rd.t3.ack",     {30'd0, ack},     32'h1);
        @(negedge clk);
        drive(2'b00, 2'b00, 2'b00, 32'h0, 32'h0, 8'h00, 8'h00); #1;
        chk("rd.t4.rd_valid",{30'd0, rd_valid},32'h0);
        chk("rd.t4.bus_wr",  {31'd0, bus_wr},  32'h1);
        chk("rd.t4.bus_add", bus_add,          32'h700);
        chk("rd.t4.bus_data",{24'd0, bus_data},32'h88);

        // Reset lands in the BUS_RD cycle of a read; the read must vanish.
        slave_val = 8'h5A;
        @(negedge clk);
        drive(2'b10, 2'b00, 2'b00, 32'h0, 32'h40, 8'h00, 8'h00); #1;
        chk("rst.t0.ack", {30'd0, ack}, 32'h2);
        @(negedge clk);
        rst = 1'b1;
        drive(2'b00, 2'b00, 2'b00, 32'h0, 32'h0, 8'h00, 8'h00); #1;
        chk("rst.t1.bus_rd", {31'd0, bus_rd}, 32'h1);
        @(negedge clk);
        rst = 1'b0; #1;
        chk("rst.t2.bus_rd",  {31'd0, bus_rd},  32'h0);
        chk("rst.t2.bus_wr",  {31'd0, bus_wr},  32'h0);
        chk("rst.t2.bus_add", bus_add,          32'h0);
        chk("rst.t2.owner",   {31'd0, owner},   32'h1);
        chk("rst.t2.rd_data", {24'd0, rd_data}, 32'h0);
        chk("rst.t2.ack",     {30'd0, ack},     32'h0);
        for (int k = 0; k < 4; k++) begin
            chk($sformatf("rst.no_rd_valid%0d", k), {30'd0, rd_valid}, 32'h0);
            @(negedge clk); #1;
        end
        @(negedge clk);
        drive(2'b11, 2'b11, 2'b00, 32'h800, 32'h900, 8'h11, 8'h22); #1;
        chk("rst.next.ack", {30'd0, ack}, 32'h1);
        @(negedge clk);
        drive(2'b00, 2'b00, 2'b00, 32'h0, 32'h0, 8'h00, 8'h00); #1;
        chk("rst.next.bus_add", bus_add,         32'h800);
        chk("rst.next.owner",   {31'd0, owner},  32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/bus_master_arbiter.md
Name: bus_master_arbiter

Overview:
Shares the single basil register bus (BUS_WR/BUS_RD/BUS_ADD/BUS_DATA) between N bus masters, e.g. the TCP stream writer, the RBCP/UDP path and on-chip sequencers. Each master issues single-byte read or write requests via a valid/ack handshake. The arbiter grants round-robin, supports burst lock for streamed writes, drives the bus from registers, and returns read data to the issuing master. It sits between the Ethernet front end and all bus slaves.

Parameters:
N_MASTERS, 2, number of requesters (2..8)
ABUSWIDTH, 32, bus address width
READ_LATENCY, 1, cycles from BUS_RD high to slave data valid on BUS_DATA (1..3)

Ports:
BUS_CLK  input  1  bus clock; all logic on its rising edge
BUS_RST  input  1  reset, synchronous, active-high
REQ  input  N_MASTERS  per-master request valid
REQ_WR  input  N_MASTERS  per-master 1=write, 0=read
REQ_LOCK  input  N_MASTERS  per-master hold ownership after this request
REQ_ADD  input  N_MASTERS*ABUSWIDTH  packed addresses, master i at [i*ABUSWIDTH +: ABUSWIDTH]
REQ_DATA  input  N_MASTERS*8  packed write data
ACK  output  N_MASTERS  one-hot request-accepted pulse (combinational)
RD_VALID  output  N_MASTERS  one-hot read-data-valid pulse (registered)
RD_DATA  output  8  read data, valid with RD_VALID
OWNER  output  $clog2(N_MASTERS)  index of last/current grantee
BUS_WR  output  1  registered write strobe
BUS_RD  output  1  registered read strobe
BUS_ADD  output  ABUSWIDTH  registered address
BUS_DATA  inout  8  driven with registered write data while BUS_WR=1, else high-Z

Behaviour:
- Reset: ACK=0, RD_VALID=0, RD_DATA=0, BUS_WR=0, BUS_RD=0, BUS_ADD=0, BUS_DATA Z, OWNER=N_MASTERS-1, lock cleared, state IDLE. Reset mid-transaction aborts it; no RD_VALID issued.
- States: IDLE (may accept), RD_WAIT (read outstanding). No separate write state.
- IDLE, no lock: winner = first i with REQ[i]=1 searching OWNER+1, OWNER+2, ... modulo N_MASTERS. ACK[winner]=1 same cycle; OWNER<=winner; BUS_ADD, write data, BUS_WR or BUS_RD registered, so the strobe is high exactly one cycle, the cycle after ACK. No REQ: BUS_WR=BUS_RD=0, BUS_ADD holds.
- Writes: IDLE remains; back-to-back accepts allowed, 1 write/cycle sustained.
- Reads: accept at cycle t -> BUS_RD high at t+1 -> BUS_DATA sampled at the end of cycle t+1+READ_LATENCY -> RD_VALID[owner]=1 and RD_DATA at cycle t+2+READ_LATENCY. State RD_WAIT from t+1 until RD_VALID; ACK=0 in RD_WAIT. A new accept is allowed in the RD_VALID cycle.
- Lock: set when the accepted request has REQ_LOCK=1; cleared when the owner's accepted request has REQ_LOCK=0, or when the owner drops both REQ and REQ_LOCK in IDLE. While locked, only OWNER is eligible. If the owner's REQ=0 with REQ_LOCK=1, the bus idles and others wait.
- Master must hold REQ/REQ_WR/REQ_ADD/REQ_DATA stable until ACK. Deasserting REQ before ACK withdraws the request.
- Multiple simultaneous requests: exactly one ACK bit per cycle, never two.
- BUS_DATA input sampled only in the read-capture cycle. The arbiter never drives BUS_DATA while BUS_RD=1.

Optional Feature:
BUS_ARB_FIXED_PRIO_EN: when defined, winner selection is fixed priority (lowest index wins) instead of round-robin; lock semantics are unchanged and OWNER is still updated. Without it, round-robin as above.

Decomposition:
- Package bus_arb_pkg: state enum {IDLE, RD_WAIT}, MAX_MASTERS=8, MAX_READ_LATENCY=3 constants.
- Sub-module rr_arbiter_core: combinational; inputs request vector, OWNER pointer and lock; outputs one-hot grant and index. Round-robin/fixed-priority selection lives only here.

Test Plan:
- Single write: master 0 REQ, WR=1, ADD=0x1000, DATA=0xA5 -> ACK[0] at t, BUS_WR=1, BUS_ADD=0x1000, BUS_DATA=0xA5 at t+1 only.
- Read, READ_LATENCY=1: master 1 reads 0x20, slave model returns 0x3C -> BUS_RD at t+1, RD_VALID[1]=1 with RD_DATA=0x3C at t+3, ACK=0 at t+1..t+2.
- Fairness: masters 0 and 1 request continuously (writes) -> ACK alternates 0,1,0,1; with BUS_ARB_FIXED_PRIO_EN every ACK goes to 0.
- Lock: master 1 writes 4 bytes to 0x100..0x103 with LOCK=1 on the first three while master 0 requests -> four consecutive ACK[1], then ACK[0].
- Lock stall: master 1 drops REQ for 3 cycles holding LOCK -> no ACK to master 0; bus idle; resumes on master 1 REQ.
- Reset mid-read: BUS_RST at t+1 of a read -> no RD_VALID, all outputs at reset values next cycle, next accept goes to master 0.
